pipeline_ctrl: RTL
==================

# pipeline_ctrl

Central stall/flush controller for the five-stage pipeline. It merges per-stage stall requests into the 6-bit `stall_en` vector consumed by the program counter and the pipeline registers. It sequences exception/ERET redirection through a one-cycle freeze followed by a one-cycle flush, supplying `new_pc`. A stall watchdog and a saturating stall-cycle counter guard against deadlock and support profiling.

## Interface
Parameters:
- `EXC_VECTOR`, default 32'h0000_0020: redirect target for exceptions and watchdog trips.
- `WDOG_LIMIT`, default 1024: consecutive stall cycles that trigger a trip. Legal range is 2 to 2^16-1.
- `CNT_W`, default 32: width of `stall_cycles`.

Ports:
- `clk`, input, 1: the single clock; all state updates on its rising edge.
- `reset_n`, input, 1: asynchronous, active-low reset.
- `stall_req_id`, input, 1: ID stage requests a stall (load-use hazard).
- `stall_req_ex`, input, 1: EX stage requests a stall (multi-cycle mult/div).
- `exc_valid`, input, 1: MEM stage reports an exception or ERET this cycle.
- `exc_eret`, input, 1: qualifies `exc_valid`. 1 means ERET (return to `exc_epc`); 0 means exception.
- `exc_epc`, input, 32: return address for ERET.
- `stall_en`, output, 6: bit0 PC, bit1 IF/ID, bit2 ID/EX, bit3 EX/MEM, bit4 MEM/WB, bit5 WB. 1 means hold.
- `flush`, output, 1: clear all pipeline registers and load `new_pc` this cycle.
- `new_pc`, output, 32: redirect target, valid when `flush`=1.
- `stall_cycles`, output, CNT_W: saturating count of cycles with `stall_en[0]`=1.
- `wdog_trip`, output, 1: one-cycle pulse when the watchdog fires.

## Operation
- States: RUN, FREEZE, FLUSH.

RUN:
- If `exc_valid` is high, or the watchdog count reaches `WDOG_LIMIT`-1 while a stall request is active:
  - `stall_en` = 6'b111111.
  - Latch the target: `exc_epc` if `exc_valid && exc_eret`; otherwise `EXC_VECTOR`.
  - Go to FREEZE.
- Otherwise, if `stall_req_ex` is high: `stall_en` = 6'b001111.
- Otherwise, if `stall_req_id` is high: `stall_en` = 6'b000111.
- Otherwise: `stall_en` = 6'b000000.
- Priority order is exception, then watchdog, then EX, then ID.

FREEZE:
- `stall_en` = 6'b111111 and `flush` = 0.
- Next state is FLUSH unconditionally.

FLUSH:
- `flush` = 1, `new_pc` = latched target, `stall_en` = 6'b000000.
- Next state is RUN.

General rules:
- `exc_valid` and stall requests are ignored in FREEZE and FLUSH.
- `new_pc` holds its last latched value outside FLUSH. It is 0 after reset.
- `stall_en` is combinational from state and inputs (same-cycle response). `flush`, `new_pc`, and `wdog_trip` are registered.

Watchdog:
- The watchdog counter increments each RUN cycle in which `stall_req_id` or `stall_req_ex` is high.
- It clears on any RUN cycle with no request, and on entry to FREEZE.
- A trip takes the exception path: `wdog_trip` pulses in the FREEZE cycle and the target is `EXC_VECTOR`.
- If `exc_valid` and a watchdog trip occur in the same cycle, the exception wins and `wdog_trip` stays 0.

Stall counter:
- `stall_cycles` increments when `stall_en[0]`=1, including FREEZE cycles.
- It saturates at all-ones and never wraps.

Reset:
- Assertion of `reset_n`=0 at any time, including mid-FREEZE/FLUSH, forces:
  - state RUN, `flush` 0, `new_pc` 0, `wdog_trip` 0, `stall_cycles` 0, watchdog count 0.
- `stall_en` then follows the RUN rules.

## Timing
- Stall response: zero latency; a request in cycle N gives `stall_en` in cycle N.
- Redirect:
  - `exc_valid` in cycle N.
  - Freeze (all ones) in N and N+1.
  - `flush`=1 with `new_pc` in N+2.
  - The PC loads `new_pc` at the end of N+2 and normal fetch resumes in N+3.
- Watchdog: with a continuous request starting at cycle 0, the trip decision is made in cycle `WDOG_LIMIT`-1, `wdog_trip`=1 in cycle `WDOG_LIMIT`, and `flush` in cycle `WDOG_LIMIT`+1.
- Back-to-back: an `exc_valid` presented in the FLUSH cycle is dropped; the MEM stage re-presents it after the flush if it is still valid.

## Structure
- Shared package holds:
  - stall masks `STALL_NONE`, `STALL_ID`, `STALL_EX`, `STALL_ALL`;
  - the state enum `ctrl_state_t` {RUN, FREEZE, FLUSH};
  - the `stall_en` bit-index constants shared with the program counter and pipeline registers.
- One sub-module, `stall_watchdog`: counter, clear, and limit compare, producing a trip request.
- The FSM, target latch, and stall-cycle counter stay at top level.

## Test plan
- Reset with `reset_n`=0 mid-FREEZE: all outputs cleared immediately; after release `stall_en`=0 and `new_pc`=0.
- `stall_req_id`=1 for 3 cycles: `stall_en`=6'b000111 in exactly those cycles; `stall_cycles` reaches 3.
- `stall_req_id`=`stall_req_ex`=1 simultaneously: `stall_en`=6'b001111.
- `exc_valid`=1 with `exc_eret`=0 at cycle 10: `stall_en`=6'b111111 in cycles 10 and 11; `flush`=1 and `new_pc`=32'h20 in cycle 12.
- ERET with `exc_epc`=32'h0000_1000, plus a second `exc_valid` during FLUSH: a single flush with `new_pc`=32'h1000; the second event is ignored.
- `WDOG_LIMIT`=8, `stall_req_ex` held high: `wdog_trip` pulses in cycle 8 and `flush` occurs in cycle 9 with `new_pc`=`EXC_VECTOR`. Separately, force `stall_cycles` near all-ones and hold stalls: the counter saturates and does not wrap.

Source files
------------

// File: rtl/pipeline_ctrl_pkg.sv
// Shared definitions for the pipeline stall/flush controller, the program
// counter and the pipeline registers.
package pipeline_ctrl_pkg;

    localparam int STALL_W = 6;

    // Bit positions inside stall_en (1 = hold).
    localparam int SE_PC     = 0;
    localparam int SE_IF_ID  = 1;
    localparam int SE_ID_EX  = 2;
    localparam int SE_EX_MEM = 3;
    localparam int SE_MEM_WB = 4;
    localparam int SE_WB     = 5;

    localparam logic [STALL_W-1:0] STALL_NONE = 6'b000000;
    localparam logic [STALL_W-1:0] STALL_ID   = 6'b000111;
    localparam logic [STALL_W-1:0] STALL_EX   = 6'b001111;
    localparam logic [STALL_W-1:0] STALL_ALL  = 6'b111111;

    localparam int WDOG_CNT_W = 16;

    typedef enum logic [1:0] {
        RUN    = 2'd0,
        FREEZE = 2'd1,
        FLUSH  = 2'd2
    } ctrl_state_t;

endpackage

// File: rtl/pipeline_ctrl_stall_watchdog.sv
// Counts consecutive stalled RUN cycles and requests a trip when the count
// reaches LIMIT-1 while a stall request is still active.
module stall_watchdog
    import pipeline_ctrl_pkg::*;
#(
    parameter int unsigned LIMIT = 1024
) (
    input  logic clk,
    input  logic reset_n,
    input  logic i_run,
    input  logic i_req,
    input  logic i_clear,
    output logic o_trip_req
);

    localparam logic [WDOG_CNT_W-1:0] LIMIT_M1 = WDOG_CNT_W'(LIMIT - 1);

    logic [WDOG_CNT_W-1:0] r_count;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_count <= '0;
        end else if (i_clear) begin
            r_count <= '0;
        end else if (i_run) begin
            // The count never passes LIMIT-1: a trip moves to FREEZE and clears it.
            r_count <= i_req ? (r_count + WDOG_CNT_W'(1)) : '0;
        end
    end

    assign o_trip_req = i_run && i_req && (r_count == LIMIT_M1);

endmodule

// File: rtl/pipeline_ctrl.sv
// Stall/flush controller: merges stage stall requests, sequences redirects
// through FREEZE then FLUSH, and keeps a watchdog plus a stall-cycle counter.
module pipeline_ctrl
    import pipeline_ctrl_pkg::*;
#(
    parameter logic [31:0] EXC_VECTOR = 32'h0000_0020,
    parameter int unsigned WDOG_LIMIT = 1024,
    parameter int unsigned CNT_W      = 32
) (
    input  logic               clk,
    input  logic               reset_n,
    input  logic               stall_req_id,
    input  logic               stall_req_ex,
    input  logic               exc_valid,
    input  logic               exc_eret,
    input  logic [31:0]        exc_epc,
    output logic [STALL_W-1:0] stall_en,
    output logic               flush,
    output logic [31:0]        new_pc,
    output logic [CNT_W-1:0]   stall_cycles,
    output logic               wdog_trip
);

    ctrl_state_t        r_state;
    ctrl_state_t        w_next_state;
    logic [STALL_W-1:0] w_stall_en;
    logic               w_redirect;
    logic               w_trip_req;
    logic               w_req;
    logic [31:0]        w_target_d;
    logic [31:0]        r_target;
    logic [31:0]        r_new_pc;
    logic               r_flush;
    logic               r_wdog_trip;
    logic [CNT_W-1:0]   r_stall_cycles;

    assign w_req      = stall_req_id || stall_req_ex;
    assign w_target_d = (exc_valid && exc_eret) ? exc_epc : EXC_VECTOR;

    stall_watchdog #(
        .LIMIT (WDOG_LIMIT)
    ) u_wdog (
        .clk        (clk),
        .reset_n    (reset_n),
        .i_run      (r_state == RUN),
        .i_req      (w_req),
        .i_clear    (w_redirect),
        .o_trip_req (w_trip_req)
    );

    always_comb begin
        w_next_state = r_state;
        w_stall_en   = STALL_NONE;
        w_redirect   = 1'b0;
        case (r_state)
            RUN: begin
                if (exc_valid || w_trip_req) begin
                    w_stall_en   = STALL_ALL;
                    w_redirect   = 1'b1;
                    w_next_state = FREEZE;
                end else if (stall_req_ex) begin
                    w_stall_en = STALL_EX;
                end else if (stall_req_id) begin
                    w_stall_en = STALL_ID;
                end
            end
            FREEZE: begin
                w_stall_en   = STALL_ALL;
                w_next_state = FLUSH;
            end
            FLUSH: begin
                w_next_state = RUN;
            end
            default: begin
                w_next_state = RUN;
            end
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_state <= RUN;
        end else begin
            r_state <= w_next_state;
        end
    end

    // new_pc only moves as flush rises, so it stays stable outside FLUSH.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_target    <= '0;
            r_new_pc    <= '0;
            r_flush     <= 1'b0;
            r_wdog_trip <= 1'b0;
        end else begin
            if (w_redirect) begin
                r_target <= w_target_d;
            end
            if (r_state == FREEZE) begin
                r_new_pc <= r_target;
            end
            r_flush     <= (r_state == FREEZE);
            r_wdog_trip <= w_redirect && !exc_valid;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_stall_cycles <= '0;
        end else if (w_stall_en[SE_PC] && (r_stall_cycles != '1)) begin
            r_stall_cycles <= r_stall_cycles + CNT_W'(1);
        end
    end

    assign stall_en     = w_stall_en;
    assign flush        = r_flush;
    assign new_pc       = r_new_pc;
    assign wdog_trip    = r_wdog_trip;
    assign stall_cycles = r_stall_cycles;

endmodule
